// File: rtl/pingpong_frame_scheduler.sv
// Round-robin scheduler that forwards whole frames from one of two AXI-Stream
// sources to a single output, one frame per grant, with a one-cycle DONE gap.
module pingpong_frame_scheduler #(
    parameter int unsigned DW = 128,
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic [CW-1:0] BEATS_PER_FRAME,
    input  logic [DW-1:0] s0_tdata,
    input  logic          s0_tvalid,
    output logic          s0_tready,
    input  logic [DW-1:0] s1_tdata,
    input  logic          s1_tvalid,
    output logic          s1_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic          m_tuser,
    output logic [CW-1:0] frame_count,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rr;
    logic          rr_next;
    logic          gid_next;
    logic          pick;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_cnt_next;
    logic [CW-1:0] beat_len;
    logic [CW-1:0] beat_len_next;
    logic [CW-1:0] frame_count_next;

    // State and frame bookkeeping registers; m_tuser doubles as the grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            rr          <= 1'b0;
            m_tuser     <= 1'b0;
            beat_cnt    <= '0;
            beat_len    <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            rr          <= rr_next;
            m_tuser     <= gid_next;
            beat_cnt    <= beat_cnt_next;
            beat_len    <= beat_len_next;
            frame_count <= frame_count_next;
        end
    end

    // Next-state logic and the zero-latency data path of the granted source.
    always_comb begin
        state_next       = state;
        rr_next          = rr;
        gid_next         = m_tuser;
        beat_cnt_next    = beat_cnt;
        beat_len_next    = beat_len;
        frame_count_next = frame_count;
        m_tdata          = '0;
        m_tvalid         = 1'b0;
        m_tlast          = 1'b0;
        s0_tready        = 1'b0;
        s1_tready        = 1'b0;
        busy             = (state != IDLE);
        // Preferred source if it has data, otherwise the other one.
        pick             = rr ? s1_tvalid : ~s0_tvalid;

        case (state)
            IDLE: begin
                if (enable && (s0_tvalid || s1_tvalid)) begin
                    gid_next      = pick;
                    rr_next       = ~pick;
                    beat_len_next = (BEATS_PER_FRAME == '0) ? CW'(1) : BEATS_PER_FRAME;
                    beat_cnt_next = '0;
                    state_next    = XFER;
                end
            end
            XFER: begin
                m_tdata   = m_tuser ? s1_tdata : s0_tdata;
                m_tvalid  = m_tuser ? s1_tvalid : s0_tvalid;
                s0_tready = ~m_tuser & m_tready;
                s1_tready = m_tuser & m_tready;
                m_tlast   = (beat_cnt == beat_len - CW'(1));
                if (m_tvalid && m_tready) begin
                    if (m_tlast) begin
                        state_next = DONE;
                    end else begin
                        beat_cnt_next = beat_cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                frame_count_next = frame_count + CW'(1);
                state_next       = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pingpong_frame_scheduler.sv
// Randomised and directed bench for pingpong_frame_scheduler, checked every cycle
// against a frame-level reference model of the scheduling rules.
module tb_pingpong_frame_scheduler;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          resetn;
    logic          enable;
    logic [CW-1:0] beats;
    logic [DW-1:0] s0_tdata;
    logic          s0_tvalid;
    logic          s0_tready;
    logic [DW-1:0] s1_tdata;
    logic          s1_tvalid;
    logic          s1_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          m_tuser;
    logic [CW-1:0] frame_count;
    logic          busy;

    pingpong_frame_scheduler #(.DW(DW), .CW(CW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .enable         (enable),
        .BEATS_PER_FRAME(beats),
        .s0_tdata       (s0_tdata),
        .s0_tvalid      (s0_tvalid),
        .s0_tready      (s0_tready),
        .s1_tdata       (s1_tdata),
        .s1_tvalid      (s1_tvalid),
        .s1_tready      (s1_tready),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .m_tuser        (m_tuser),
        .frame_count    (frame_count),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 idle, 1 in a frame, 2 completion gap.
    int ph, gid, rr, len, beat, frames;
    int idx0, idx1, cur_beats;
    int mode;            // 0 hold inputs, 1 toggle m_tready, 2 random
    int fr_user[$];
    int fr_beats[$];
    int dq[$];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fr_u(input int i);
        return (i < fr_user.size()) ? fr_user[i] : -1;
    endfunction

    function automatic int fr_b(input int i);
        return (i < fr_beats.size()) ? fr_beats[i] : -1;
    endfunction

    // One clock cycle: drive, compare at negedge, advance model, return at posedge+1.
    task automatic cycle();
        bit xf, ev, eh;
        if (mode == 1) m_tready = ~m_tready;
        if (mode == 2) begin
            enable    = ($urandom_range(0, 9) < 8);
            s0_tvalid = ($urandom_range(0, 3) != 0);
            s1_tvalid = ($urandom_range(0, 2) != 0);
            m_tready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) beats = CW'($urandom_range(0, 6));
        end
        s0_tdata = DW'(idx0);
        s1_tdata = DW'(32'h8000 + idx1);
        @(negedge clk);
        xf = (ph == 1);
        ev = xf && (gid == 1 ? s1_tvalid : s0_tvalid);
        chk("m_tvalid", m_tvalid, ev);
        chk("m_tdata", m_tdata, xf ? (gid == 1 ? s1_tdata : s0_tdata) : 0);
        chk("s0_tready", s0_tready, xf && gid == 0 && m_tready);
        chk("s1_tready", s1_tready, xf && gid == 1 && m_tready);
        chk("m_tlast", m_tlast, xf && beat == len - 1);
        chk("m_tuser", m_tuser, gid);
        chk("frame_count", frame_count, frames % (1 << CW));
        chk("busy", busy, ph != 0);
        if (m_tvalid && m_tready) begin
            cur_beats++;
            dq.push_back(int'(m_tdata));
            if (m_tlast) begin
                chk("frame_len", cur_beats, len);
                fr_user.push_back(int'(m_tuser));
                fr_beats.push_back(cur_beats);
                cur_beats = 0;
            end
        end
        eh = ev && m_tready;
        case (ph)
            0: if (enable && (s0_tvalid || s1_tvalid)) begin
                gid  = ((rr == 1) ? s1_tvalid : s0_tvalid) ? rr : 1 - rr;
                rr   = 1 - gid;
                len  = (beats == 0) ? 1 : int'(beats);
                beat = 0;
                ph   = 1;
            end
            1: if (eh) begin
                if (gid == 0) idx0++; else idx1++;
                if (beat == len - 1) ph = 2; else beat++;
            end
            default: begin
                frames++;
                ph = 0;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges: outputs must clear before any clock edge.
    task automatic do_reset();
        #1 resetn = 1'b0;
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        chk("rst_m_tuser", m_tuser, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_busy", busy, 0);
        ph = 0; gid = 0; rr = 0; len = 0; beat = 0; frames = 0;
        idx0 = 0; idx1 = 0; cur_beats = 0;
        fr_user.delete(); fr_beats.delete(); dq.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic run_frames(input int n, input int budget);
        int c = 0;
        while (fr_user.size() < n && c < budget) begin
            cycle();
            c++;
        end
        chk("frames_done", fr_user.size(), n);
    endtask

    initial begin
        int cyc;
        resetn = 1'b0; enable = 1'b0; beats = '0; mode = 0;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b0;
        s0_tdata = '0; s1_tdata = '0;
        ph = 0; gid = 0; rr = 0; len = 0; beat = 0; frames = 0;
        idx0 = 0; idx1 = 0; cur_beats = 0;
        @(posedge clk);
        #1;

        // Both sources busy, 4-beat frames: s0,s1,s0 with a DONE+IDLE gap.
        enable = 1'b1; s0_tvalid = 1'b1; s1_tvalid = 1'b1; m_tready = 1'b1;
        beats = CW'(4);
        do_reset();
        cyc = 0;
        while (fr_user.size() < 3 && cyc < 40) begin
            cycle();
            cyc++;
        end
        chk("a_cycles", cyc, 17);
        chk("a_user0", fr_u(0), 0);
        chk("a_user1", fr_u(1), 1);
        chk("a_user2", fr_u(2), 0);
        chk("a_beats0", fr_b(0), 4);
        chk("a_beats2", fr_b(2), 4);
        cycle();
        chk("a_fc", frame_count, 3);

        // Only s1 offers data while rr favours s0.
        s0_tvalid = 1'b0; s1_tvalid = 1'b1; beats = CW'(3);
        do_reset();
        run_frames(1, 20);
        chk("b_user", fr_u(0), 1);
        chk("b_beats", fr_b(0), 3);
        s0_tvalid = 1'b1;
        cycle();
        chk("b_fc", frame_count, 1);
        run_frames(2, 20);
        chk("b_next_user", fr_u(1), 0);

        // Backpressure toggling on a 5-beat frame: each beat exactly once, in order.
        s0_tvalid = 1'b1; s1_tvalid = 1'b0; beats = CW'(5); m_tready = 1'b1;
        do_reset();
        mode = 1;
        run_frames(1, 40);
        mode = 0;
        m_tready = 1'b1;
        chk("c_beats", fr_b(0), 5);
        chk("c_handshakes", dq.size(), 5);
        for (int i = 0; i < 5; i++) chk("c_data", (i < dq.size()) ? dq[i] : -1, i);

        // Zero beat count behaves as a single-beat frame.
        s0_tvalid = 1'b1; s1_tvalid = 1'b1; beats = '0;
        do_reset();
        run_frames(1, 10);
        chk("d_beats", fr_b(0), 1);

        // Reset at beat 2 of an s1 frame; afterwards s0 must win first.
        beats = CW'(4);
        do_reset();
        run_frames(1, 20);
        cycle();
        cycle();
        chk("e_pre_fc", frame_count, 1);
        cycle();
        chk("e_s1_granted", m_tuser, 1);
        cycle();
        cycle();
        do_reset();
        cycle();
        cycle();
        chk("e_post_user", m_tuser, 0);
        chk("e_post_fc", frame_count, 0);

        // Counter wrap on a 4-bit build.
        beats = CW'(1);
        do_reset();
        run_frames(15, 80);
        cycle();
        chk("f_fc15", frame_count, 15);
        run_frames(16, 10);
        cycle();
        chk("f_fc_wrap", frame_count, 0);

        // Random traffic, occasional resets.
        mode = 2;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (i % 700 == 699) do_reset();
        end
        chk("g_some_frames", (frames > 20) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pingpong_frame_scheduler.md
PINGPONG_FRAME_SCHEDULER -- requirements
Module: pingpong_frame_scheduler

Interface
REQ-001 Parameter DW, default 128: data width of all stream ports.
REQ-002 Parameter CW, default 32: width of beat and frame counters.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous assert and active-low; synchronous deassert is the integrator's responsibility.
REQ-005 enable  in  1  1 = may start new frames; sampled only in IDLE.
REQ-006 BEATS_PER_FRAME  in  CW  beats per frame (FRAME_SIZE/PACKET_SIZE, computed upstream); latched at grant.
REQ-007 s0_tdata/s0_tvalid/s0_tready  in/in/out  DW/1/1  ping source AXI-Stream.
REQ-008 s1_tdata/s1_tvalid/s1_tready  in/in/out  DW/1/1  pong source AXI-Stream.
REQ-009 m_tdata/m_tvalid/m_tready  out/out/in  DW/1/1  scheduled output stream toward the header adder.
REQ-010 m_tlast  out  1  high on the final beat of each frame.
REQ-011 m_tuser  out  1  granted source id (0 = s0, 1 = s1), valid while m_tvalid.
REQ-012 frame_count  out  CW  number of frames completed since reset.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, XFER, DONE; encoding is free.
REQ-015 IDLE: when enable=1 and at least one of s0_tvalid/s1_tvalid=1, the block SHALL grant a source, latch the beat count, clear the beat counter and move to XFER on the next edge.
REQ-016 Grant SHALL use the round-robin pointer rr: grant source rr if its tvalid=1, otherwise grant the other source (work-conserving).
REQ-017 On a grant rr SHALL be set to the complement of the granted id, so both sources valid alternates s0,s1,s0,...
REQ-018 A latched BEATS_PER_FRAME of 0 SHALL be treated as 1.
REQ-019 XFER: m_tdata, m_tvalid = granted sX_tdata, sX_tvalid, combinationally (zero latency); granted sX_tready = m_tready; non-granted tready = 0.
REQ-020 A beat SHALL be transferred only on a cycle with m_tvalid=1 and m_tready=1; only then does the beat counter increment.
REQ-021 m_tlast SHALL be 1 in XFER when beat counter = latched count - 1, and 0 otherwise.
REQ-022 A transfer with m_tlast=1 SHALL move the FSM to DONE.
REQ-023 DONE SHALL last exactly one cycle with all tready and m_tvalid = 0, increment frame_count (modulo 2^CW, wrapping to 0), and return to IDLE.
REQ-024 Grant, latched count and data path SHALL NOT change within a frame; changes to BEATS_PER_FRAME or enable mid-frame SHALL take effect only at the next IDLE.
REQ-025 Deasserting enable mid-frame SHALL let the current frame complete; the FSM then waits in IDLE.
REQ-026 Source tvalid dropping mid-frame SHALL stall the output (m_tvalid=0) without aborting; the frame resumes when tvalid returns.
REQ-027 Outside XFER: m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser holds the last grant, s0_tready=s1_tready=0.

Reset
REQ-028 resetn=0 SHALL immediately force the FSM to IDLE, with rr=0, beat counter=0, latched count=0, frame_count=0, m_tuser=0, and all tready/m_tvalid/m_tlast=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; no completion is counted.
REQ-030 After resetn returns to 1, the first grant SHALL favour s0.

Verification
REQ-031 BEATS=4, both sources always valid, m_tready=1 -> frames alternate s0,s1,s0; 4 beats each; m_tlast on beat 4; frame_count 1,2,3; one DONE gap between frames.
REQ-032 BEATS=3, only s1 valid, rr=0 -> s1 granted, m_tuser=1, 3 beats, frame_count=1, next preference rr=0.
REQ-033 BEATS=5, m_tready toggling 1,0,1,0 -> exactly 5 handshakes, data in order, no beat duplicated or lost, s0_tready follows m_tready.
REQ-034 BEATS=0 -> a single-beat frame with m_tlast=1 on the first beat.
REQ-035 Async reset asserted at beat 2 of 4 between clock edges -> outputs zero before the next edge, frame_count=0; after release, s0 is granted first.
REQ-036 frame_count preset near wrap (CW=4 build, 16 frames) -> frame_count wraps 15->0, with no other effect.
